// File: rtl/uart_bridge_pkg.sv
// uart_bridge_pkg
// Shared types and helpers for the UART frame bridge.
//   - rx_state_t / tx_state_t : inbound assembly and outbound serialiser states
//   - BYTE_W, MAX_BYTES       : byte width and largest supported frame payload
//   - cnt_width()             : counter width able to hold 0..max_val
//   - xor_bytes()             : XOR of every byte of a zero-extended payload
// Optional feature macro used by the files importing this package: CHECKSUM_EN.
package uart_bridge_pkg;

  localparam int BYTE_W    = 8;
  localparam int MAX_BYTES = 64;

  typedef enum logic [1:0] {
    R_COLLECT = 2'd0,
    R_LAUNCH  = 2'd1,
    R_WAIT    = 2'd2
  } rx_state_t;

  typedef enum logic [1:0] {
    T_IDLE = 2'd0,
    T_SEND = 2'd1,
    T_GAP  = 2'd2
  } tx_state_t;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // Unused upper bytes must be zero so they do not disturb the result.
  function automatic logic [BYTE_W-1:0] xor_bytes(input logic [BYTE_W*MAX_BYTES-1:0] v);
    logic [BYTE_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      acc = acc ^ v[BYTE_W*i +: BYTE_W];
    end
    return acc;
  endfunction

endpackage

// File: rtl/frame_serializer.sv
// frame_serializer
// Latches a core result on core_done and sends it to the UART transmitter
// one byte at a time, MSB-first.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   core_done       : one-cycle strobe, core_dout valid (ignored unless idle)
//   core_dout       : OUT_BYTES-byte result word
//   tx_busy         : transmitter busy; a byte is only issued while low
//   tx_valid/tx_byte: one-cycle byte strobe and data
//   idle            : high while no frame is being sent
//   dbg_state       : current tx_state_t encoding
// Macro CHECKSUM_EN: appends the XOR of the result bytes as a final byte.
//
// Transmit handshake: tx_valid is a one-cycle strobe issued only in a cycle
// where tx_busy was sampled low; the transmitter raises tx_busy the cycle after
// tx_valid, so one gap cycle is spent before tx_busy is looked at again.
module frame_serializer
  import uart_bridge_pkg::*;
#(
  parameter int OUT_BYTES = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        core_done,
  input  logic [BYTE_W*OUT_BYTES-1:0] core_dout,
  input  logic                        tx_busy,
  output logic                        tx_valid,
  output logic [BYTE_W-1:0]           tx_byte,
  output logic                        idle,
  output logic [1:0]                  dbg_state
);

`ifdef CHECKSUM_EN
  localparam int NB = OUT_BYTES + 1;
`else
  localparam int NB = OUT_BYTES;
`endif
  localparam int IDX_W = cnt_width(NB);
  localparam int SH_W  = BYTE_W * NB;

  tx_state_t        r_state;
  logic [SH_W-1:0]  r_shift;
  logic [IDX_W-1:0] r_idx;
  logic [SH_W-1:0]  w_load;

`ifdef CHECKSUM_EN
  logic [BYTE_W*MAX_BYTES-1:0] w_dout_ext;

  always_comb begin
    w_dout_ext = '0;
    w_dout_ext[BYTE_W*OUT_BYTES-1:0] = core_dout;
    w_load = {core_dout, xor_bytes(w_dout_ext)};
  end
`else
  always_comb begin
    w_load = core_dout;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= T_IDLE;
      r_shift  <= '0;
      r_idx    <= '0;
      tx_valid <= 1'b0;
      tx_byte  <= '0;
    end else begin
      tx_valid <= 1'b0;
      case (r_state)
        T_IDLE: begin
          if (core_done) begin
            r_shift <= w_load;
            r_idx   <= '0;
            r_state <= T_SEND;
          end
        end
        T_SEND: begin
          if (!tx_busy) begin
            tx_byte  <= r_shift[SH_W-1 -: BYTE_W];
            tx_valid <= 1'b1;
            r_state  <= T_GAP;
          end
        end
        T_GAP: begin
          // Next byte moves to the top of the shift register.
          r_shift <= r_shift << BYTE_W;
          r_idx   <= r_idx + IDX_W'(1);
          if (r_idx == IDX_W'(NB - 1)) begin
            r_state <= T_IDLE;
          end else begin
            r_state <= T_SEND;
          end
        end
        default: r_state <= T_IDLE;
      endcase
    end
  end

  assign idle      = (r_state == T_IDLE);
  assign dbg_state = r_state;

endmodule

// File: rtl/uart_frame_bridge.sv
// uart_frame_bridge
// Collects IN_BYTES UART bytes (MSB-first) into one word, launches the compute
// core with core_start, and returns the OUT_BYTES result over the UART via
// frame_serializer. A partial inbound frame idle for TIMEOUT_CYCLES is dropped.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   rx_valid/rx_byte      : one-cycle received-byte strobe and data
//   tx_busy               : transmitter busy
//   tx_valid/tx_byte      : one-cycle byte strobe to the transmitter
//   core_start            : one-cycle launch pulse
//   core_din              : frame to the core, held from core_start to core_done
//   core_done/core_dout   : one-cycle result strobe and result word
//   overrun               : sticky, an inbound byte was dropped
//   timeout_evt           : one-cycle pulse, a partial frame was discarded
//   chk_err               : (CHECKSUM_EN only) one-cycle pulse, bad frame checksum
//   dbg_rx_state          : current rx_state_t encoding
//   dbg_tx_state          : current tx_state_t encoding of the serialiser
// Macro CHECKSUM_EN: inbound frames carry a trailing XOR byte, outbound frames
// get one appended.
//
// Core handshake: core_start is a one-cycle pulse, core_din is frozen until the
// matching core_done pulse; only one launch is ever outstanding.
module uart_frame_bridge
  import uart_bridge_pkg::*;
#(
  parameter int IN_BYTES       = 32,
  parameter int OUT_BYTES      = 32,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        rx_valid,
  input  logic [BYTE_W-1:0]           rx_byte,
  input  logic                        tx_busy,
  output logic                        tx_valid,
  output logic [BYTE_W-1:0]           tx_byte,
  output logic                        core_start,
  output logic [BYTE_W*IN_BYTES-1:0]  core_din,
  input  logic                        core_done,
  input  logic [BYTE_W*OUT_BYTES-1:0] core_dout,
  output logic                        overrun,
  output logic                        timeout_evt,
`ifdef CHECKSUM_EN
  output logic                        chk_err,
`endif
  output logic [1:0]                  dbg_rx_state,
  output logic [1:0]                  dbg_tx_state
);

`ifdef CHECKSUM_EN
  localparam int FRAME_LEN = IN_BYTES + 1;
`else
  localparam int FRAME_LEN = IN_BYTES;
`endif
  localparam int CNT_W = cnt_width(FRAME_LEN);
  localparam int TO_W  = cnt_width(TIMEOUT_CYCLES);

  rx_state_t                  r_state;
  logic [CNT_W-1:0]           r_count;
  logic [TO_W-1:0]            r_idle;
  logic [BYTE_W*IN_BYTES-1:0] r_asm;
  logic                       w_tx_idle;

`ifdef CHECKSUM_EN
  logic [BYTE_W*MAX_BYTES-1:0] w_asm_ext;

  always_comb begin
    w_asm_ext = '0;
    w_asm_ext[BYTE_W*IN_BYTES-1:0] = r_asm;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= R_COLLECT;
      r_count     <= '0;
      r_idle      <= '0;
      r_asm       <= '0;
      core_start  <= 1'b0;
      core_din    <= '0;
      overrun     <= 1'b0;
      timeout_evt <= 1'b0;
`ifdef CHECKSUM_EN
      chk_err     <= 1'b0;
`endif
    end else begin
      core_start  <= 1'b0;
      timeout_evt <= 1'b0;
`ifdef CHECKSUM_EN
      chk_err     <= 1'b0;
`endif
      if (rx_valid) begin
        r_idle <= '0;
      end
      case (r_state)
        R_COLLECT: begin
          if (rx_valid) begin
            // Byte k lands in the k-th byte lane from the top. With the
            // checksum enabled the trailing byte matches no lane.
            for (int k = 0; k < IN_BYTES; k++) begin
              if (r_count == CNT_W'(k)) begin
                r_asm[BYTE_W*(IN_BYTES-1-k) +: BYTE_W] <= rx_byte;
              end
            end
            if (r_count == CNT_W'(FRAME_LEN - 1)) begin
              r_count <= '0;
`ifdef CHECKSUM_EN
              if (rx_byte == xor_bytes(w_asm_ext)) begin
                r_state <= R_LAUNCH;
              end else begin
                chk_err <= 1'b1;
              end
`else
              r_state <= R_LAUNCH;
`endif
            end else begin
              r_count <= r_count + CNT_W'(1);
            end
          end else if ((TIMEOUT_CYCLES != 0) && (r_count != '0)) begin
            // A byte arriving on the expiry cycle takes the branch above,
            // so it is kept and no timeout fires.
            if (r_idle == TO_W'(TIMEOUT_CYCLES - 1)) begin
              r_count     <= '0;
              r_idle      <= '0;
              timeout_evt <= 1'b1;
            end else begin
              r_idle <= r_idle + TO_W'(1);
            end
          end
        end
        R_LAUNCH: begin
          if (rx_valid) begin
            overrun <= 1'b1;
          end
          // R_LAUNCH is only reached after the previous R_WAIT saw core_done,
          // so the core itself is free; the result path must also be idle.
          if (w_tx_idle) begin
            core_din   <= r_asm;
            core_start <= 1'b1;
            r_state    <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (rx_valid) begin
            overrun <= 1'b1;
          end
          if (core_done) begin
            r_state <= R_COLLECT;
          end
        end
        default: r_state <= R_COLLECT;
      endcase
    end
  end

  frame_serializer #(
    .OUT_BYTES (OUT_BYTES)
  ) u_ser (
    .clk       (clk),
    .reset     (reset),
    .core_done (core_done),
    .core_dout (core_dout),
    .tx_busy   (tx_busy),
    .tx_valid  (tx_valid),
    .tx_byte   (tx_byte),
    .idle      (w_tx_idle),
    .dbg_state (dbg_tx_state)
  );

  assign dbg_rx_state = r_state;

endmodule

// File: tb/tb_uart_frame_bridge.sv
// tb_uart_frame_bridge
// Directed bench for uart_frame_bridge (IN_BYTES=32, OUT_BYTES=32,
// TIMEOUT_CYCLES=100). Expected core_din words and tx bytes are queued when
// stimulus is issued and popped by a negedge monitor. Honours CHECKSUM_EN.
module tb_uart_frame_bridge;
  import uart_bridge_pkg::*;

  localparam int IN_B   = 32;
  localparam int OUT_B  = 32;
  localparam int TO_CYC = 100;
`ifdef CHECKSUM_EN
  localparam int TX_LEN = OUT_B + 1;
`else
  localparam int TX_LEN = OUT_B;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             rx_valid = 1'b0;
  logic [7:0]       rx_byte = 8'h00;
  logic             tx_busy = 1'b0;
  logic             tx_valid;
  logic [7:0]       tx_byte;
  logic             core_start;
  logic [8*IN_B-1:0]  core_din;
  logic             core_done = 1'b0;
  logic [8*OUT_B-1:0] core_dout = '0;
  logic             overrun;
  logic             timeout_evt;
  logic [1:0]       dbg_rx_state;
  logic [1:0]       dbg_tx_state;
`ifdef CHECKSUM_EN
  logic             chk_err;
`endif

  always #5 clk = ~clk;

  uart_frame_bridge #(
    .IN_BYTES       (IN_B),
    .OUT_BYTES      (OUT_B),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_valid     (rx_valid),
    .rx_byte      (rx_byte),
    .tx_busy      (tx_busy),
    .tx_valid     (tx_valid),
    .tx_byte      (tx_byte),
    .core_start   (core_start),
    .core_din     (core_din),
    .core_done    (core_done),
    .core_dout    (core_dout),
    .overrun      (overrun),
    .timeout_evt  (timeout_evt),
`ifdef CHECKSUM_EN
    .chk_err      (chk_err),
`endif
    .dbg_rx_state (dbg_rx_state),
    .dbg_tx_state (dbg_tx_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [7:0]        exp_q[$];
  logic [8*IN_B-1:0] exp_din_q[$];
  logic [8*IN_B-1:0] mon_din;
  logic [7:0]        mon_byte;
  int tx_seen = 0;
  int to_seen = 0;
  int start_seen = 0;
  int chk_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (core_start) begin
          start_seen++;
          checks++;
          if (exp_din_q.size() == 0) begin
            failures++;
            $display("FAIL core_start_unexpected: got core_din 0x%0h expected no launch", core_din);
          end else begin
            mon_din = exp_din_q.pop_front();
            if (core_din !== mon_din) begin
              failures++;
              $display("FAIL core_din: got 0x%0h expected 0x%0h", core_din, mon_din);
            end
          end
        end
        if (tx_valid) begin
          tx_seen++;
          check("tx_only_when_not_busy", tx_busy, 1'b0);
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL tx_unexpected: got 0x%0h expected no byte", tx_byte);
          end else begin
            mon_byte = exp_q.pop_front();
            if (tx_byte !== mon_byte) begin
              failures++;
              $display("FAIL tx_byte: got 0x%0h expected 0x%0h", tx_byte, mon_byte);
            end
          end
        end
        if (timeout_evt) to_seen++;
`ifdef CHECKSUM_EN
        if (chk_err) chk_seen++;
`endif
      end
    end
  end

  // Transmitter model: busy rises the cycle after tx_valid, for 3 cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && tx_valid) begin
        @(posedge clk); #1 tx_busy = 1'b1;
        repeat (3) @(posedge clk);
        #1 tx_busy = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [8*IN_B-1:0] build_din(input logic [7:0] base);
    logic [8*IN_B-1:0] v;
    v = '0;
    for (int i = 0; i < IN_B; i++) v[8*(IN_B-1-i) +: 8] = 8'(base + i);
    return v;
  endfunction

  function automatic logic [7:0] xor_seq(input logic [7:0] base, input int n);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < n; i++) x = x ^ 8'(base + i);
    return x;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1 rx_valid = 1'b1; rx_byte = b;
    @(posedge clk); #1 rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] base);
    exp_din_q.push_back(build_din(base));
    for (int i = 0; i < IN_B; i++) send_byte(8'(base + i));
`ifdef CHECKSUM_EN
    send_byte(xor_seq(base, IN_B));
`endif
  endtask

  task automatic wait_start(input string name);
    int n;
    n = 0;
    while (!core_start && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!core_start) begin
      failures++;
      $display("FAIL %s: got no core_start after %0d cycles, required a launch", name, n);
    end
  endtask

  task automatic do_done(input logic [7:0] base);
    logic [8*OUT_B-1:0] v;
    v = '0;
    for (int i = 0; i < OUT_B; i++) begin
      v[8*(OUT_B-1-i) +: 8] = 8'(base + i);
      exp_q.push_back(8'(base + i));
    end
`ifdef CHECKSUM_EN
    exp_q.push_back(xor_seq(base, OUT_B));
`endif
    @(posedge clk); #1 core_done = 1'b1; core_dout = v;
    @(posedge clk); #1 core_done = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, exp_q.size(), 0);
    repeat (10) @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  int n;
  int tx_base;
  int st_base;
  int chk_base;

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_byte", tx_byte, 8'h00);
    check("rst_core_start", core_start, 1'b0);
    check("rst_core_din_any", 64'(|core_din), 0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_timeout_evt", timeout_evt, 1'b0);
    check("rst_rx_state", dbg_rx_state, 64'(R_COLLECT));
    check("rst_tx_state", dbg_tx_state, 64'(T_IDLE));
    @(posedge clk); #1 reset = 1'b0;

    // Frame 0x00..0x1F; launch two cycles after the last rx_valid.
    send_frame(8'h00);
    check("start_not_yet", core_start, 1'b0);
    @(posedge clk); #1;
    check("start_latency_2", core_start, 1'b1);
    @(posedge clk); #1;
    check("start_one_cycle", core_start, 1'b0);
    tx_base = tx_seen;
    repeat (48) @(posedge clk);
    #1;
    do_done(8'hA0);
    drain("tx_frame_a0");
    check("tx_count_frame_a0", tx_seen - tx_base, TX_LEN);

    // Partial frame times out after 100 idle cycles.
    for (int i = 0; i < 5; i++) send_byte(8'(8'h50 + i));
    n = 0;
    while (!timeout_evt && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("timeout_idle_cycle", n, TO_CYC);
    @(posedge clk); #1;
    check("timeout_one_cycle", timeout_evt, 1'b0);

    // Clean frame afterwards; byte 1 arrives exactly on the would-be expiry.
    exp_din_q.push_back(build_din(8'h60));
    send_byte(8'h60);
    repeat (TO_CYC - 2) @(posedge clk);
    send_byte(8'h61);
    for (int i = 2; i < IN_B; i++) send_byte(8'(8'h60 + i));
`ifdef CHECKSUM_EN
    send_byte(xor_seq(8'h60, IN_B));
`endif
    wait_start("start_after_timeout");
    check("timeout_total_events", to_seen, 1);
    repeat (20) @(posedge clk);
    do_done(8'h30);
    drain("tx_frame_30");

    // Overrun: extra byte while waiting for the core.
    send_frame(8'h20);
    wait_start("start_ovr_frame");
    check("overrun_clear_before", overrun, 1'b0);
    send_byte(8'hEE);
    check("overrun_set", overrun, 1'b1);
    repeat (40) @(posedge clk);
    do_done(8'h55);
    drain("tx_frame_55");
    send_frame(8'h80);
    wait_start("start_after_overrun");
    check("overrun_sticky", overrun, 1'b1);
    repeat (10) @(posedge clk);
    do_done(8'h05);
    drain("tx_frame_05");

    // Reset while the result is being sent.
    send_frame(8'h40);
    wait_start("start_rst_frame");
    repeat (10) @(posedge clk);
    tx_base = tx_seen;
    do_done(8'hC0);
    n = 0;
    while (tx_seen < tx_base + 10 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check("tx_before_reset", tx_seen - tx_base, 10);
    n = 0;
    while (!tx_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("tx_byte11_strobe", tx_valid, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("tx_valid_cleared_by_reset", tx_valid, 1'b0);
    exp_q.delete();
    check("reset_overrun_cleared", overrun, 1'b0);
    check("reset_tx_state", dbg_tx_state, 64'(T_IDLE));
    @(posedge clk); #1 reset = 1'b0;
    tx_base = tx_seen;
    repeat (300) @(posedge clk);
    #1;
    check("no_tx_after_reset", tx_seen - tx_base, 0);
    send_frame(8'h10);
    wait_start("start_after_reset");
    repeat (15) @(posedge clk);
    tx_base = tx_seen;
    do_done(8'h70);
    drain("tx_frame_70");
    check("tx_count_frame_70", tx_seen - tx_base, TX_LEN);

`ifdef CHECKSUM_EN
    // Bad checksum: error pulse and no launch.
    chk_base = chk_seen;
    st_base = start_seen;
    for (int i = 0; i < IN_B; i++) send_byte(8'(8'h90 + i));
    send_byte(xor_seq(8'h90, IN_B) ^ 8'h5A);
    repeat (20) @(posedge clk);
    #1;
    check("chk_err_pulse", chk_seen - chk_base, 1);
    check("chk_bad_no_start", start_seen - st_base, 0);
    send_frame(8'h90);
    wait_start("start_good_chk");
    check("chk_good_no_err", chk_seen - chk_base, 1);
    repeat (5) @(posedge clk);
    tx_base = tx_seen;
    do_done(8'hE1);
    drain("tx_frame_e1");
    check("tx_count_with_chk", tx_seen - tx_base, OUT_B + 1);
`else
    chk_base = 0;
    st_base = 0;
`endif

    check("din_queue_empty", exp_din_q.size(), 0);
    check("tx_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
